// File: rtl/psr_cond_unit.sv
// PSR latch and branch-condition evaluator for the execute stage.
// Optional shadow PSR / interrupt FSM enabled by defining PSR_SHADOW_EN.
`ifndef PRSWIDTH
`define PRSWIDTH 5
`endif
`ifndef psrC
`define psrC 0
`endif
`ifndef psrL
`define psrL 1
`endif
`ifndef psrF
`define psrF 2
`endif
`ifndef psrZ
`define psrZ 3
`endif
`ifndef psrN
`define psrN 4
`endif

module psr_cond_unit #(
    parameter int PSR_W  = `PRSWIDTH,
    parameter int COND_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [PSR_W-1:0]  psrIn,
    input  logic [PSR_W-1:0]  flagWe,
    input  logic              stall,
    input  logic              condValid,
    input  logic [COND_W-1:0] condCode,
    input  logic              intEnter,
    input  logic              intExit,
    output logic [PSR_W-1:0]  psrOut,
    output logic              takeBranch,
    output logic              branchValid,
    output logic              inIsr,
    output logic              nestErr
);

    logic [PSR_W-1:0] psr_next;
    logic             cond_hit;
    logic             fz, fc, fl, ff, fn;

    always_comb begin
        for (int i = 0; i < PSR_W; i++)
            psr_next[i] = flagWe[i] ? psrIn[i] : psrOut[i];
    end

    // Conditions see the flags being written this cycle (compare+branch bypass).
    assign fz = psr_next[`psrZ];
    assign fc = psr_next[`psrC];
    assign fl = psr_next[`psrL];
    assign ff = psr_next[`psrF];
    assign fn = psr_next[`psrN];

    always_comb begin
        cond_hit = 1'b0;
        case (condCode)
            COND_W'(0):  cond_hit = fz;
            COND_W'(1):  cond_hit = !fz;
            COND_W'(2):  cond_hit = fc;
            COND_W'(3):  cond_hit = !fc;
            COND_W'(4):  cond_hit = !fl && !fz;
            COND_W'(5):  cond_hit = fl || fz;
            COND_W'(6):  cond_hit = fl;
            COND_W'(7):  cond_hit = !fl;
            COND_W'(8):  cond_hit = !fn && !fz;
            COND_W'(9):  cond_hit = fn || fz;
            COND_W'(10): cond_hit = ff;
            COND_W'(11): cond_hit = !ff;
            COND_W'(12): cond_hit = fn;
            COND_W'(13): cond_hit = !fn;
            COND_W'(14): cond_hit = 1'b1;
            default:     cond_hit = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            takeBranch  <= 1'b0;
            branchValid <= 1'b0;
        end else if (stall) begin
            branchValid <= 1'b0;
        end else begin
            branchValid <= condValid;
            if (condValid)
                takeBranch <= cond_hit;
        end
    end

`ifdef PSR_SHADOW_EN
    typedef enum logic {NORMAL, ISR} state_t;

    state_t           state, state_nxt;
    logic [PSR_W-1:0] shadow, shadow_nxt, psr_d;
    logic             err_nxt;

    always_comb begin
        state_nxt  = state;
        shadow_nxt = shadow;
        psr_d      = psr_next;
        err_nxt    = nestErr;
        if (stall) begin
            psr_d = psrOut;
        end else begin
            case (state)
                NORMAL: begin
                    if (intEnter) begin
                        shadow_nxt = psr_next;
                        state_nxt  = ISR;
                    end
                    if (intExit)
                        err_nxt = 1'b1;
                end
                ISR: begin
                    // Restore takes precedence over any flag write this cycle.
                    if (intExit) begin
                        psr_d     = shadow;
                        state_nxt = NORMAL;
                    end
                    if (intEnter)
                        err_nxt = 1'b1;
                end
                default: state_nxt = NORMAL;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= NORMAL;
            shadow  <= '0;
            psrOut  <= '0;
            nestErr <= 1'b0;
        end else begin
            state   <= state_nxt;
            shadow  <= shadow_nxt;
            psrOut  <= psr_d;
            nestErr <= err_nxt;
        end
    end

    assign inIsr = (state == ISR);
`else
    logic unused_int;
    assign unused_int = intEnter ^ intExit;

    always_ff @(posedge clk) begin
        if (reset)
            psrOut <= '0;
        else if (!stall)
            psrOut <= psr_next;
    end

    assign inIsr   = 1'b0;
    assign nestErr = 1'b0;
`endif

endmodule
